// File: rtl/jk_input_conditioner.sv
// ============================================================================
// Module   : jk_input_conditioner
// Brief    : Synchronizes, debounces and edge-detects two push buttons into
//            clean J/K drives for a JK flip-flop, with a press event counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jk_input_conditioner #(
  parameter int STABLE_CNT = 8,
  parameter int CNT_W      = 4
) (
  input  logic       Clk,
  input  logic       rst,
  input  logic       btn_j,
  input  logic       btn_k,
  input  logic       pulse_mode,
  output logic       J,
  output logic       K,
  output logic [7:0] ev_cnt
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(STABLE_CNT - 1);

  logic [1:0] w_btn;
  logic [1:0] w_deb;
  logic [1:0] w_rise;

  assign w_btn = {btn_k, btn_j};

  generate
    for (genvar g = 0; g < 2; g++) begin : g_chan
      logic             r_s1;
      logic             r_s2;
      logic             r_deb;
      logic             r_deb_d;
      logic [CNT_W-1:0] r_cnt;

      // Any cycle agreeing with the debounced state restarts the count.
      always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
          r_s1    <= 1'b0;
          r_s2    <= 1'b0;
          r_deb   <= 1'b0;
          r_deb_d <= 1'b0;
          r_cnt   <= '0;
        end else begin
          r_s1    <= w_btn[g];
          r_s2    <= r_s1;
          r_deb_d <= r_deb;
          if (r_s2 == r_deb) begin
            r_cnt <= '0;
          end else if (r_cnt == C_CNT_MAX) begin
            r_deb <= r_s2;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      assign w_deb[g]  = r_deb;
      assign w_rise[g] = r_deb & ~r_deb_d;
    end
  endgenerate

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      J      <= 1'b0;
      K      <= 1'b0;
      ev_cnt <= 8'd0;
    end else begin
      J <= pulse_mode ? w_rise[0] : w_deb[0];
      K <= pulse_mode ? w_rise[1] : w_deb[1];
      // A simultaneous J/K press counts as a single event.
      if (|w_rise) begin
        ev_cnt <= ev_cnt + 8'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jk_input_conditioner.sv
// ============================================================================
// Module   : tb_jk_input_conditioner
// Brief    : Self-checking bench for jk_input_conditioner against a
//            window-based behavioural model, directed and random stimulus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jk_input_conditioner;

  localparam int STABLE = 8;

  logic       Clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_j = 1'b0;
  logic       btn_k = 1'b0;
  logic       pulse_mode = 1'b0;
  logic       J;
  logic       K;
  logic [7:0] ev_cnt;

  int n_vec = 0;
  int n_bad = 0;

  jk_input_conditioner #(.STABLE_CNT(STABLE), .CNT_W(4)) dut (
    .Clk        (Clk),
    .rst        (rst),
    .btn_j      (btn_j),
    .btn_k      (btn_k),
    .pulse_mode (pulse_mode),
    .J          (J),
    .K          (K),
    .ev_cnt     (ev_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: raw_x[i] is the button value sampled i+1 edges ago.
  // The debounced state flips once the last STABLE synchronized samples
  // (raw_x[1..STABLE]) all disagree with it.
  logic [STABLE:0] raw_j, raw_k;
  logic            m_deb_j, m_deb_k, m_prev_j, m_prev_k, m_j, m_k;
  logic [7:0]      m_ev;

  function automatic logic settles(input logic [STABLE:0] raw, input logic deb);
    for (int i = 1; i <= STABLE; i++) begin
      if (raw[i] == deb) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge Clk or negedge rst) begin
    if (!rst) begin
      raw_j <= '0; raw_k <= '0;
      m_deb_j <= 1'b0; m_deb_k <= 1'b0;
      m_prev_j <= 1'b0; m_prev_k <= 1'b0;
      m_j <= 1'b0; m_k <= 1'b0; m_ev <= 8'd0;
    end else begin
      m_j  <= pulse_mode ? (m_deb_j & ~m_prev_j) : m_deb_j;
      m_k  <= pulse_mode ? (m_deb_k & ~m_prev_k) : m_deb_k;
      m_ev <= m_ev + 8'((m_deb_j & ~m_prev_j) | (m_deb_k & ~m_prev_k));
      m_prev_j <= m_deb_j;
      m_prev_k <= m_deb_k;
      if (settles(raw_j, m_deb_j)) m_deb_j <= ~m_deb_j;
      if (settles(raw_k, m_deb_k)) m_deb_k <= ~m_deb_k;
      raw_j <= {raw_j[STABLE-1:0], btn_j};
      raw_k <= {raw_k[STABLE-1:0], btn_k};
    end
  end

  // Per-cycle comparison against the model, plus output activity tallies.
  int j_hi = 0, k_hi = 0, jk_hi = 0;
  always @(negedge Clk) begin
    check("J", 32'(J), 32'(m_j));
    check("K", 32'(K), 32'(m_k));
    check("ev_cnt", 32'(ev_cnt), 32'(m_ev));
    j_hi  <= j_hi + int'(J);
    k_hi  <= k_hi + int'(K);
    jk_hi <= jk_hi + int'(J & K);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #2;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; btn_j = 1'b0; btn_k = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(1);
  endtask

  int s_j, s_k, s_jk;
  int hold_j, hold_k;

  initial begin
    #1;
    check("rst_J", 32'(J), 0);
    check("rst_K", 32'(K), 0);
    check("rst_ev", 32'(ev_cnt), 0);

    // Clean press, pulse mode: J pulse exactly 11 edges after the change.
    do_reset();
    pulse_mode = 1'b1;
    s_j = j_hi;
    btn_j = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      @(posedge Clk);
      #1;
      if (e == 10) check("lat_pre", 32'(J), 0);
      if (e == 11) check("lat_hit", 32'(J), 1);
      if (e == 12) check("lat_post", 32'(J), 0);
      #1;
    end
    tick(20);
    check("p1_jcnt", 32'(j_hi - s_j), 1);
    check("p1_ev", 32'(ev_cnt), 1);

    // Bouncing K, then steady high: one K pulse.
    do_reset();
    pulse_mode = 1'b1;
    s_k = k_hi;
    for (int c = 0; c < 20; c++) begin
      if (c % 3 == 0) btn_k = ~btn_k;
      tick(1);
    end
    check("bounce_k_quiet", 32'(k_hi - s_k), 0);
    btn_k = 1'b1;
    tick(30);
    check("bounce_kcnt", 32'(k_hi - s_k), 1);
    check("bounce_ev", 32'(ev_cnt), 1);

    // Simultaneous presses: single joint pulse, single event.
    do_reset();
    pulse_mode = 1'b1;
    s_jk = jk_hi;
    btn_j = 1'b1; btn_k = 1'b1;
    tick(20);
    check("both_cnt", 32'(jk_hi - s_jk), 1);
    check("both_ev", 32'(ev_cnt), 1);

    // Level mode: 30-cycle hold gives 30 cycles of J.
    do_reset();
    pulse_mode = 1'b0;
    s_j = j_hi;
    btn_j = 1'b1;
    tick(30);
    btn_j = 1'b0;
    tick(20);
    check("lvl_jcnt", 32'(j_hi - s_j), 30);
    check("lvl_ev", 32'(ev_cnt), 1);

    // 256 presses wrap the event counter.
    do_reset();
    pulse_mode = 1'b1;
    s_j = j_hi;
    for (int p = 0; p < 256; p++) begin
      btn_j = 1'b1;
      tick(14);
      btn_j = 1'b0;
      tick(14);
    end
    check("wrap_jcnt", 32'(j_hi - s_j), 256);
    check("wrap_ev", 32'(ev_cnt), 0);

    // Reset during a partially debounced press.
    do_reset();
    pulse_mode = 1'b1;
    btn_j = 1'b1;
    tick(6);
    rst = 1'b0;
    #1;
    check("midrst_J", 32'(J), 0);
    check("midrst_K", 32'(K), 0);
    check("midrst_ev", 32'(ev_cnt), 0);
    tick(2);
    rst = 1'b1;
    btn_j = 1'b0;
    s_j = j_hi;
    tick(20);
    check("midrst_nopulse", 32'(j_hi - s_j), 0);

    // Random bouncing, mode flips and occasional resets.
    do_reset();
    hold_j = 0; hold_k = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold_j == 0) begin
        btn_j  = ~btn_j;
        hold_j = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 30) : $urandom_range(1, 9);
      end
      if (hold_k == 0) begin
        btn_k  = ~btn_k;
        hold_k = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 30) : $urandom_range(1, 9);
      end
      hold_j--; hold_k--;
      if ($urandom_range(0, 63) == 0) pulse_mode = ~pulse_mode;
      rst = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
      tick(1);
    end
    rst = 1'b1;
    tick(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/jk_input_conditioner.md
Name: jk_input_conditioner

Overview:
Upstream stage for the JK flip-flop. Takes two raw, bouncing, asynchronous push-button inputs and produces clean, clock-synchronous J and K drive signals.
- Per channel: 2-FF synchronizer, counter-based debouncer, registered output stage.
- Selectable output form: one-cycle pulse per press, or debounced level.
- A wrapping event counter supports bench and on-board observation.

Parameters:
STABLE_CNT, 8, consecutive cycles the synchronized input must differ from the debounced state before that state changes (legal range 2..2^CNT_W).
CNT_W, 4, width of each per-channel debounce counter. Must hold the value STABLE_CNT-1.

Ports:
Clk  input  1  system clock, rising-edge active.
rst  input  1  asynchronous, active-low reset; clears all state.
btn_j  input  1  raw J button; asynchronous, may bounce.
btn_k  input  1  raw K button; asynchronous, may bounce.
pulse_mode  input  1  synchronous to Clk. 1 = J/K are one-cycle pulses on press; 0 = J/K follow the debounced level.
J  output  1  registered J drive to the JK flip-flop.
K  output  1  registered K drive to the JK flip-flop.
ev_cnt  output  8  count of cycles in which a press pulse (J, K or both) was generated; wraps.

Behaviour:
- Reset (rst=0, asynchronous): all synchronizer flops, debounced states, edge-delay flops, counters, J, K and ev_cnt are 0. After rst deasserts, no output activity until a raw input goes high.
- Synchronizer: per channel, s1 <= btn, s2 <= s1. No other logic reads the raw inputs.
- Debouncer, per channel (registers deb, cnt):
  - If s2 == deb: cnt <= 0.
  - Else if cnt == STABLE_CNT-1: deb <= s2, cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any cycle with s2 == deb restarts the count, so a glitch shorter than STABLE_CNT cycles at s2 never changes deb.
- Edge detect, per channel: deb_d <= deb; rise = deb & ~deb_d. Release edges produce nothing.
- Output stage (registered):
  - pulse_mode=1: J <= rise_j, K <= rise_k.
  - pulse_mode=0: J <= deb_j, K <= deb_k.
- Latency, raw input stable from just before edge 0:
  - s2 valid at edge 2.
  - deb changes at edge 2+STABLE_CNT.
  - J/K change at edge 3+STABLE_CNT (edge 11 at the default).
  - Identical latency in both modes.
  - In pulse mode, J/K are high for exactly one cycle per debounced press.
- Simultaneous presses: if rise_j and rise_k occur in the same cycle, J and K are both high in the same cycle (toggle request). Channels are fully independent; no arbitration.
- ev_cnt:
  - Increments by 1 on each edge where (rise_j | rise_k) is 1, in either mode.
  - Increments by 1, not 2, when both rise together.
  - 8-bit wrap: 255 -> 0.
- pulse_mode change:
  - Sampled each edge; takes effect on the next output update.
  - Switching 0->1 while deb is high yields no pulse; J drops to 0 on the next edge.
  - Switching 1->0 while deb is high drives J high on the next edge.
- Reset mid-operation: immediate clear of everything, including partially counted debounce intervals; a held button is re-debounced from scratch after release of reset.
- Holding a button indefinitely:
  - Pulse mode: one pulse only.
  - Level mode: J/K stay high until release is debounced; release reaches J/K with the same 3+STABLE_CNT latency.

Test Plan:
- Reset, then btn_j=1 clean at t0, pulse_mode=1 -> J=1 for exactly one cycle at edge 11, J=0 thereafter, K=0, ev_cnt=1.
- Bouncing btn_k, toggling every 3 cycles for 20 cycles, then steady 1, pulse_mode=1 -> no K activity during bounce; exactly one K pulse 11 edges after the last transition; ev_cnt=1.
- btn_j and btn_k rise on the same edge, pulse_mode=1 -> J=K=1 in the same single cycle; ev_cnt increments by exactly 1.
- pulse_mode=0, btn_j high for 30 cycles then low -> J rises at edge 11, stays 1, falls 11 edges after release; ev_cnt +1.
- 256 clean separated presses on btn_j -> 256 single-cycle J pulses; ev_cnt wraps to 0.
- btn_j high for 6 cycles, then rst=0 for 2 cycles, release btn_j -> J, K and ev_cnt read 0 immediately on rst assertion; no J pulse after reset release.
